// File: rtl/sram8t.sv
// Behavioural 8T SRAM: separate read/write ports on a shared address, with registered read data.
// Optional macro SRAM8T_BYPASS_EN: a same-cycle read and write forwards din to dout.
module sram8t #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  re,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;

  // Read and write share addr, so a concurrent write always targets the word being read.
  always_comb begin
    rd_word = mem[addr];
`ifdef SRAM8T_BYPASS_EN
    if (we) rd_word = din;
`endif
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      dout <= '0;
    end else if (cs) begin
      if (we) mem[addr] <= din;
      if (re) dout <= rd_word;
    end
  end

endmodule

// File: tb/tb_sram8t.sv
// Scoreboard bench for sram8t: stimulus queues expected dout values, and a monitor checks them.
module tb_sram8t;

  logic       clk;
  logic       rst_n;
  logic       cs;
  logic       re;
  logic       we;
  logic [3:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   chk_pending = 0;
  bit   async_flag = 0;
  event async_ev;

`ifdef SRAM8T_BYPASS_EN
  localparam logic [7:0] SAME_ADDR_EXP = 8'h11;
`else
  localparam logic [7:0] SAME_ADDR_EXP = 8'hAA;
`endif

  sram8t #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .cs   (cs),
    .re   (re),
    .we   (we),
    .addr (addr),
    .din  (din),
    .dout (dout)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // One clock cycle of stimulus; when chk is set, dout is checked just after this cycle's rising edge.
  task automatic cyc(input logic c, input logic r, input logic w, input logic [3:0] a,
                     input logic [7:0] d, input bit chk, input logic [7:0] e, input string nm);
    @(negedge clk);
    cs = c; re = r; we = w; addr = a; din = d;
    if (chk) exp_q.push_back('{exp: e, name: nm});
    chk_pending = chk;
  endtask

  task automatic compare_one();
    exp_t t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL no_expectation: dout=%02h with empty scoreboard", dout);
    end else begin
      t = exp_q.pop_front();
      if (dout !== t.exp) begin
        errors++;
        $display("FAIL %s: dout=%02h expected=%02h", t.name, dout, t.exp);
      end
    end
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk or async_ev);
      if (async_flag) begin
        async_flag = 0;
        #1 compare_one();
      end else if (chk_pending) begin
        #1 compare_one();
      end
    end
  end

  initial begin : stimulus
    rst_n = 1; cs = 0; re = 0; we = 0; addr = '0; din = '0;
    #10 rst_n = 0;

    // Every word must read zero after reset.
    for (int i = 0; i < 16; i++)
      cyc(1, 1, 0, 4'(i), 8'h00, 1, 8'h00, $sformatf("reset_read_%0d", i));

    // Write then read, and the value holds once reads stop.
    cyc(1, 0, 1, 4'd2, 8'hAA, 0, 8'h00, "");
    cyc(1, 1, 0, 4'd2, 8'h00, 1, 8'hAA, "read_after_write");
    cyc(1, 0, 0, 4'd2, 8'h00, 1, 8'hAA, "hold_re0");
    cyc(0, 1, 0, 4'd7, 8'h00, 1, 8'hAA, "hold_cs0");

    // A write with cs low must not reach the array.
    cyc(0, 0, 1, 4'd2, 8'h55, 1, 8'hAA, "cs0_write_hold");
    cyc(1, 1, 0, 4'd2, 8'h00, 1, 8'hAA, "cs0_write_blocked");

    // Simultaneous read and write to the same address.
    cyc(1, 1, 1, 4'd2, 8'h11, 1, SAME_ADDR_EXP, "same_addr_rw");
    cyc(1, 1, 0, 4'd2, 8'h00, 1, 8'h11, "after_same_addr_rw");

    // Boundary addresses must not alias.
    cyc(1, 0, 1, 4'd15, 8'hF0, 0, 8'h00, "");
    cyc(1, 0, 1, 4'd0,  8'h0F, 0, 8'h00, "");
    cyc(1, 1, 0, 4'd15, 8'h00, 1, 8'hF0, "read_addr15");
    cyc(1, 1, 0, 4'd0,  8'h00, 1, 8'h0F, "read_addr0");
    cyc(1, 1, 0, 4'd2,  8'h00, 1, 8'h11, "read_addr2_intact");

    // Assert reset between edges; dout must clear without waiting for a clock edge.
    @(negedge clk);
    cs = 1; re = 0; we = 1; addr = 4'd5; din = 8'h77;
    chk_pending = 0;
    #2 rst_n = 1;
    exp_q.push_back('{exp: 8'h00, name: "async_reset_dout"});
    async_flag = 1;
    -> async_ev;
    @(negedge clk);
    @(negedge clk);
    rst_n = 0; we = 0;
    cyc(1, 1, 0, 4'd2,  8'h00, 1, 8'h00, "post_reset_addr2");
    cyc(1, 1, 0, 4'd15, 8'h00, 1, 8'h00, "post_reset_addr15");
    cyc(1, 1, 0, 4'd5,  8'h00, 1, 8'h00, "write_during_reset_ignored");
    cyc(0, 0, 0, 4'd0,  8'h00, 0, 8'h00, "");
    @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
